// File: rtl/nn_pkg.sv
// Shared types and constants for the 32->8->2 layer sequencer: FSM state
// encoding, default layer geometry and weight-store base addresses.
package nn_pkg;

    localparam int NN_WIDTH      = 32;
    localparam int NN_WIDTH_W    = 9;
    localparam int NN_LENGHT_I   = 32;
    localparam int NN_LENGHT_MID = 8;
    localparam int NN_LENGHT_O   = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        L1_CLR = 3'd1,
        L1_MAC = 3'd2,
        L1_WB  = 3'd3,
        L2_CLR = 3'd4,
        L2_MAC = 3'd5,
        L2_WB  = 3'd6,
        DONE   = 3'd7
    } nn_state_t;

    // Weight store layout: layer-1 matrix, layer-2 matrix, then one bias per neuron.
    function automatic int l2_w_base_of(input int li, input int lm);
        return li * lm;
    endfunction

    function automatic int bias_base_of(input int li, input int lm, input int lo);
        return li * lm + lm * lo;
    endfunction

    localparam int L2_W_BASE = l2_w_base_of(NN_LENGHT_I, NN_LENGHT_MID);
    localparam int BIAS_BASE = bias_base_of(NN_LENGHT_I, NN_LENGHT_MID, NN_LENGHT_O);

endpackage

// File: rtl/nn_act_sat.sv
// Combinational saturator from the MAC accumulator width down to the data
// width; RELU=1 additionally clamps negative values to zero.
module nn_act_sat #(
    parameter int ACC_W = 47,
    parameter int WIDTH = 32,
    parameter bit RELU  = 1'b0
) (
    input  logic [ACC_W-1:0] acc,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    logic neg;
    logic hi_zeros;
    logic hi_ones;

    // The value fits when every bit above the target sign bit matches the sign.
    assign neg      = acc[ACC_W-1];
    assign hi_zeros = ~|acc[ACC_W-2:WIDTH-1];
    assign hi_ones  = &acc[ACC_W-2:WIDTH-1];

    always_comb begin
        if (!neg) begin
            result = hi_zeros ? acc[WIDTH-1:0] : MAX_V;
        end else if (RELU) begin
            result = '0;
        end else begin
            result = hi_ones ? acc[WIDTH-1:0] : MIN_V;
        end
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Walks the hidden and output layers on the shared MAC, keeping hidden
// activations locally. Define NN_SEQ_BIAS_EN to preload each neuron's bias.
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int WIDTH      = NN_WIDTH,
    parameter int WIDTH_W    = NN_WIDTH_W,
    parameter int LENGHT_I   = NN_LENGHT_I,
    parameter int LENGHT_MID = NN_LENGHT_MID,
    parameter int LENGHT_O   = NN_LENGHT_O,
    parameter int WIDTH_ADDR = $clog2(LENGHT_I*LENGHT_MID+LENGHT_MID*LENGHT_O+LENGHT_I+LENGHT_O+3),
    parameter int ACC_W      = WIDTH + WIDTH_W + 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [WIDTH_ADDR-1:0]       w_addr,
    input  logic [WIDTH_W-1:0]          w_data,
    output logic [$clog2(LENGHT_I)-1:0] x_addr,
    input  logic [WIDTH-1:0]            x_data,
    output logic                        mac_clr,
    output logic                        mac_en,
    output logic [WIDTH-1:0]            mac_a,
    output logic [WIDTH_W-1:0]          mac_b,
    input  logic [ACC_W-1:0]            mac_acc,
    output logic                        o_we,
    output logic [$clog2(LENGHT_O)-1:0] o_addr,
    output logic [WIDTH-1:0]            o_data
);

    localparam int K_W     = $clog2(LENGHT_I);
    localparam int J_W     = $clog2(LENGHT_MID);
    localparam int O_W     = $clog2(LENGHT_O);
    localparam int L2_BASE = l2_w_base_of(LENGHT_I, LENGHT_MID);

    nn_state_t      state;
    nn_state_t      state_next;
    logic [J_W-1:0] j;
    logic [J_W-1:0] j_next;
    logic [K_W-1:0] k;
    logic [K_W-1:0] k_next;

    logic [WIDTH-1:0]      hid [LENGHT_MID];
    logic [WIDTH-1:0]      hid_val;
    logic [WIDTH-1:0]      out_val;
    logic [WIDTH_ADDR-1:0] l1_addr;
    logic [WIDTH_ADDR-1:0] l2_addr;

    assign l1_addr = WIDTH_ADDR'(32'(j) * LENGHT_I + 32'(k));
    assign l2_addr = WIDTH_ADDR'(L2_BASE + 32'(j) * LENGHT_MID + 32'(k));

`ifdef NN_SEQ_BIAS_EN
    localparam int B_BASE = bias_base_of(LENGHT_I, LENGHT_MID, LENGHT_O);

    logic [WIDTH_ADDR-1:0] b1_addr;
    logic [WIDTH_ADDR-1:0] b2_addr;

    assign b1_addr = WIDTH_ADDR'(B_BASE + 32'(j));
    assign b2_addr = WIDTH_ADDR'(B_BASE + LENGHT_MID + 32'(j));
`endif

    nn_act_sat #(.ACC_W(ACC_W), .WIDTH(WIDTH), .RELU(1'b1)) u_relu_sat (
        .acc    (mac_acc),
        .result (hid_val)
    );

    nn_act_sat #(.ACC_W(ACC_W), .WIDTH(WIDTH), .RELU(1'b0)) u_out_sat (
        .acc    (mac_acc),
        .result (out_val)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            j     <= '0;
            k     <= '0;
            for (int i = 0; i < LENGHT_MID; i++) begin
                hid[i] <= '0;
            end
        end else begin
            state <= state_next;
            j     <= j_next;
            k     <= k_next;
            if (state == L1_WB) begin
                hid[j] <= hid_val;
            end
        end
    end

    always_comb begin
        state_next = state;
        j_next     = j;
        k_next     = k;
        case (state)
            IDLE: begin
                if (start) begin
                    j_next     = '0;
                    state_next = L1_CLR;
                end
            end
            L1_CLR: begin
                k_next     = '0;
                state_next = L1_MAC;
            end
            L1_MAC: begin
                if (k == K_W'(LENGHT_I - 1)) begin
                    state_next = L1_WB;
                end else begin
                    k_next = k + 1'b1;
                end
            end
            L1_WB: begin
                if (j == J_W'(LENGHT_MID - 1)) begin
                    j_next     = '0;
                    state_next = L2_CLR;
                end else begin
                    j_next     = j + 1'b1;
                    state_next = L1_CLR;
                end
            end
            L2_CLR: begin
                k_next     = '0;
                state_next = L2_MAC;
            end
            L2_MAC: begin
                if (k == K_W'(LENGHT_MID - 1)) begin
                    state_next = L2_WB;
                end else begin
                    k_next = k + 1'b1;
                end
            end
            L2_WB: begin
                if (j == J_W'(LENGHT_O - 1)) begin
                    j_next     = '0;
                    state_next = DONE;
                end else begin
                    j_next     = j + 1'b1;
                    state_next = L2_CLR;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Every output is zero unless the current state drives it.
    always_comb begin
        busy    = (state != IDLE);
        done    = 1'b0;
        w_addr  = '0;
        x_addr  = '0;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        mac_a   = '0;
        mac_b   = '0;
        o_we    = 1'b0;
        o_addr  = '0;
        o_data  = '0;
        case (state)
            L1_CLR, L2_CLR: begin
                mac_clr = 1'b1;
`ifdef NN_SEQ_BIAS_EN
                mac_en  = 1'b1;
                mac_a   = WIDTH'(1);
                mac_b   = w_data;
                w_addr  = (state == L1_CLR) ? b1_addr : b2_addr;
`endif
            end
            L1_MAC: begin
                mac_en = 1'b1;
                x_addr = k;
                mac_a  = x_data;
                w_addr = l1_addr;
                mac_b  = w_data;
            end
            L2_MAC: begin
                mac_en = 1'b1;
                mac_a  = hid[k[J_W-1:0]];
                w_addr = l2_addr;
                mac_b  = w_data;
            end
            L2_WB: begin
                o_we   = 1'b1;
                o_addr = j[O_W-1:0];
                o_data = out_val;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Randomized and directed bench for nn_layer_sequencer against an
// arithmetic reference of the two-layer inference.
module tb_nn_layer_sequencer;

    localparam int WIDTH      = 32;
    localparam int WIDTH_W    = 9;
    localparam int LENGHT_I   = 32;
    localparam int LENGHT_MID = 8;
    localparam int LENGHT_O   = 2;
    localparam int WIDTH_ADDR = 9;
    localparam int ACC_W      = WIDTH + WIDTH_W + 6;
    localparam int L2_BASE    = LENGHT_I * LENGHT_MID;
    localparam int B_BASE     = L2_BASE + LENGHT_MID * LENGHT_O;
    localparam int DONE_CYC   = 1 + LENGHT_MID * (LENGHT_I + 2) + LENGHT_O * (LENGHT_MID + 2);
`ifdef NN_SEQ_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [WIDTH_ADDR-1:0] w_addr;
    logic [WIDTH_W-1:0]    w_data;
    logic [4:0]            x_addr;
    logic [WIDTH-1:0]      x_data;
    logic                  mac_clr;
    logic                  mac_en;
    logic [WIDTH-1:0]      mac_a;
    logic [WIDTH_W-1:0]    mac_b;
    logic [ACC_W-1:0]      mac_acc;
    logic                  o_we;
    logic [0:0]            o_addr;
    logic [WIDTH-1:0]      o_data;

    logic signed [WIDTH_W-1:0] w_mem [0:(1<<WIDTH_ADDR)-1];
    logic signed [WIDTH-1:0]   x_mem [0:LENGHT_I-1];
    longint                    acc_l;
    logic [WIDTH:0]            exp_q[$];
    int                        total;
    int                        bad;

    nn_layer_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .x_addr  (x_addr),
        .x_data  (x_data),
        .mac_clr (mac_clr),
        .mac_en  (mac_en),
        .mac_a   (mac_a),
        .mac_b   (mac_b),
        .mac_acc (mac_acc),
        .o_we    (o_we),
        .o_addr  (o_addr),
        .o_data  (o_data)
    );

    // Clock / reset and the environment: weight/input stores and the MAC unit.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign w_data  = w_mem[w_addr];
    assign x_data  = x_mem[x_addr];
    assign mac_acc = acc_l[ACC_W-1:0];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_l <= 0;
        end else if (mac_clr && mac_en) begin
            acc_l <= longint'($signed(mac_a)) * longint'($signed(mac_b));
        end else if (mac_clr) begin
            acc_l <= 0;
        end else if (mac_en) begin
            acc_l <= acc_l + longint'($signed(mac_a)) * longint'($signed(mac_b));
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] relu_sat_m(input longint v);
        if (v < 0) return '0;
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        return v[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sat_m(input longint v);
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        return v[WIDTH-1:0];
    endfunction

    // Reference: plain dot products per neuron, then the output queue.
    task automatic load_expect();
        longint hidm [LENGHT_MID];
        longint s;
        exp_q.delete();
        for (int jj = 0; jj < LENGHT_MID; jj++) begin
            s = BIAS_EN ? longint'(w_mem[B_BASE + jj]) : 0;
            for (int kk = 0; kk < LENGHT_I; kk++)
                s += longint'(x_mem[kk]) * longint'(w_mem[jj * LENGHT_I + kk]);
            hidm[jj] = longint'(relu_sat_m(s));
        end
        for (int jj = 0; jj < LENGHT_O; jj++) begin
            s = BIAS_EN ? longint'(w_mem[B_BASE + LENGHT_MID + jj]) : 0;
            for (int kk = 0; kk < LENGHT_MID; kk++)
                s += hidm[kk] * longint'(w_mem[L2_BASE + jj * LENGHT_MID + kk]);
            exp_q.push_back({1'(jj), sat_m(s)});
        end
    endtask

    // mode: 0 ones, 1 negative L1 weights, 2 saturating, 3 bias, 4 random wide, 5 random small
    task automatic load(input int mode);
        for (int i = 0; i < (1 << WIDTH_ADDR); i++) begin
            case (mode)
                0: w_mem[i] = (i < B_BASE) ? 9'sd1 : 9'sd0;
                1: w_mem[i] = (i < L2_BASE) ? -9'sd1 : ((i < B_BASE) ? 9'sd1 : 9'sd0);
                2: w_mem[i] = (i < L2_BASE) ? 9'sd255 : ((i < B_BASE) ? 9'sd1 : 9'sd0);
                3: w_mem[i] = (i < L2_BASE) ? 9'sd0 : ((i < B_BASE) ? 9'sd1 : 9'sd5);
                4: w_mem[i] = 9'($urandom_range(0, 511));
                default: w_mem[i] = 9'($urandom_range(0, 40)) - 9'd20;
            endcase
        end
        for (int i = 0; i < LENGHT_I; i++) begin
            case (mode)
                0: x_mem[i] = 32'sd1;
                1: x_mem[i] = 32'sd5;
                2: x_mem[i] = 32'sh4000_0000;
                3: x_mem[i] = 32'($urandom());
                4: x_mem[i] = 32'($urandom());
                default: x_mem[i] = 32'($urandom_range(0, 2000)) - 32'd1000;
            endcase
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_o_we"}, o_we, 0);
        check({tag, "_clr"}, mac_clr, 0);
        check({tag, "_en"}, mac_en, 0);
        check({tag, "_w_addr"}, w_addr, 0);
        check({tag, "_x_addr"}, x_addr, 0);
        check({tag, "_mac_a"}, mac_a, 0);
        check({tag, "_mac_b"}, mac_b, 0);
        check({tag, "_o_addr"}, o_addr, 0);
        check({tag, "_o_data"}, o_data, 0);
    endtask

    // Driver + monitor for one inference; cycle n counts edges after the start edge.
    task automatic run_once(input string name, input bit extra_start, input int abort_at);
        logic [WIDTH:0] e;
        bit aborted;
        aborted = 1'b0;
        load_expect();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= DONE_CYC + 7 && !aborted; n++) begin
            @(negedge clk);
            start = extra_start && (n == 50 || n == DONE_CYC);
            if (n == abort_at) begin
                reset = 1'b1;
                #1 check_idle({name, "_abort"});
                aborted = 1'b1;
                exp_q.delete();
            end else begin
                check({name, "_busy"}, busy, n <= DONE_CYC);
                check({name, "_done"}, done, n == DONE_CYC);
                check({name, "_o_we"}, o_we, n == DONE_CYC - 11 || n == DONE_CYC - 1);
                if (n == 1) begin
                    check({name, "_clr_c1"}, mac_clr, 1);
                    check({name, "_en_c1"}, mac_en, BIAS_EN);
                end
                if (n == 2) check({name, "_en_c2"}, mac_en, 1);
                if (o_we) begin
                    if (exp_q.size() == 0) begin
                        check({name, "_extra_write"}, 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check({name, "_o_addr"}, o_addr, e[WIDTH]);
                        check({name, "_o_data"}, o_data, e[WIDTH-1:0]);
                    end
                end
            end
        end
        start = 1'b0;
        if (aborted) begin
            for (int n = 0; n < 6; n++) begin
                @(negedge clk);
                reset = 1'b0;
                check({name, "_post_abort_busy"}, busy, 0);
                check({name, "_post_abort_o_we"}, o_we, 0);
                check({name, "_post_abort_done"}, done, 0);
            end
        end else begin
            check({name, "_missing_writes"}, exp_q.size(), 0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        load(0);
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle("idle");

        load(0);
        run_once("ones", 1'b0, 0);
        load(1);
        run_once("relu", 1'b0, 0);
        load(2);
        run_once("sat", 1'b0, 0);
        load(0);
        run_once("ign_start", 1'b1, 0);
        run_once("rerun", 1'b0, 0);
        run_once("abort", 1'b0, 100);
        run_once("after_abort", 1'b0, 0);
        for (int r = 0; r < 2; r++) begin
            load(4);
            run_once("rand_wide", 1'b0, 0);
            load(5);
            run_once("rand_small", 1'b0, 0);
        end
`ifdef NN_SEQ_BIAS_EN
        load(3);
        run_once("bias", 1'b0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Sequences the fully-connected 32→8→2 inference on the shared multiply-accumulate datapath once the manager has loaded weights and inputs. It walks every neuron of the hidden and output layers, driving weight and input addresses and MAC controls. It applies ReLU and saturation, keeps hidden activations in an internal buffer and writes the final outputs back to the manager's output region. It sits between the manager's register file (`w_o`, input registers) and the MAC unit, and runs on one start pulse.

## Interface
- WIDTH, 32, input/activation/output data width, signed
- WIDTH_W, 9, weight width, signed
- LENGHT_I, 32, input neurons
- LENGHT_MID, 8, hidden neurons
- LENGHT_O, 2, output neurons
- WIDTH_ADDR, $clog2(LENGHT_I*LENGHT_MID+LENGHT_MID*LENGHT_O+LENGHT_I+LENGHT_O+3), weight address width
- ACC_W, WIDTH+WIDTH_W+6, MAC accumulator width, signed
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  begin inference; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- w_addr  out  WIDTH_ADDR  weight index into manager weight store
- w_data  in  WIDTH_W  weight at w_addr, combinational read
- x_addr  out  $clog2(LENGHT_I)  input neuron index
- x_data  in  WIDTH  input at x_addr, combinational read
- mac_clr, mac_en  out  1  MAC controls (see Operation)
- mac_a  out  WIDTH  activation operand
- mac_b  out  WIDTH_W  weight operand
- mac_acc  in  ACC_W  MAC accumulator register
- o_we  out  1  output write strobe
- o_addr  out  $clog2(LENGHT_O)  output neuron index
- o_data  out  WIDTH  saturated output value

## Operation
- MAC contract: at the clock edge, clr only sets acc to 0; en only sets acc to acc+a*b; clr and en together set acc to a*b. mac_acc is valid the cycle after.
- FSM states: IDLE, L1_CLR, L1_MAC, L1_WB, L2_CLR, L2_MAC, L2_WB, DONE. Counters: neuron j, term k.
- IDLE: if start, j=0 and go to L1_CLR.
- L1_CLR: mac_clr=1, k=0 → L1_MAC.
- L1_MAC: mac_en=1, x_addr=k, mac_a=x_data, w_addr=j*LENGHT_I+k, mac_b=w_data. After k=LENGHT_I-1 → L1_WB.
- L1_WB: hid[j] = relu_sat(mac_acc). If j=LENGHT_MID-1 then j=0 and → L2_CLR, else j++ and → L1_CLR.
- L2_MAC: mac_a=hid[k], w_addr=LENGHT_I*LENGHT_MID+j*LENGHT_MID+k, runs LENGHT_MID cycles; x_addr=0.
- L2_WB: o_we=1, o_addr=j, o_data=sat(mac_acc) (no ReLU). If j=LENGHT_O-1 → DONE, else j++ and → L2_CLR.
- DONE: done=1 → IDLE.
- relu_sat: acc<0 → 0; acc>2^(WIDTH-1)-1 → 2^(WIDTH-1)-1; else acc[WIDTH-1:0].
- sat: clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- mac_b is sign-extended by the MAC. The sequencer does no arithmetic beyond the saturators and address math.
- start while busy is ignored, with no queuing.
- hid persists between runs. Every entry is overwritten before it is read.

## Timing
- All outputs are Moore-decoded from registered state and counters.
- Outputs in IDLE and at reset: all 0, including busy, done, o_we, addresses and operands. hid resets to 0.
- start sampled at edge 0 gives L1_CLR in cycle 1.
  - Layer 1 takes LENGHT_MID*(LENGHT_I+2)=272 cycles.
  - Layer 2 takes LENGHT_O*(LENGHT_MID+2)=20 cycles.
  - done is high in cycle 293. busy is high in cycles 1–293.
- o_we pulses in cycles 282 and 292, for o_addr 0 then 1.
- Reset mid-run: immediate return to IDLE with all outputs 0. No o_we or done is issued for the aborted run.

## Configuration
- NN_SEQ_BIAS_EN defined: L1_CLR/L2_CLR assert mac_clr and mac_en together with mac_a=1.
  - w_addr is the bias address LENGHT_I*LENGHT_MID+LENGHT_MID*LENGHT_O+n, where n=j for layer 1 and n=LENGHT_MID+j for layer 2.
  - The accumulator therefore starts at the bias.
- Undefined: CLR states assert mac_clr only, so the accumulator starts at 0. Latency is identical either way.

## Structure
- Package nn_pkg holds:
  - the state enum
  - the base-address constants (L2_W_BASE, BIAS_BASE)
  - shared parameter defaults for LENGHT_* and WIDTH*
- Sub-module nn_act_sat: combinational saturator, with parameter RELU selecting ReLU or plain signed saturation. Instantiated twice.

## Test plan
- All weights 1, all inputs 1, no bias → hid=32 each; o_data 256 at o_addr 0 and 1; done in cycle 293.
- Layer-1 weights -1, inputs 5 → hid=0 via ReLU; outputs 0.
- Inputs 2^30, layer-1 weights 255, layer-2 weights 1 → hid=0x7FFFFFFF; outputs 0x7FFFFFFF (saturated).
- start pulses in cycles 50 and 293 ignored → single done. A new start after IDLE gives an identical second result.
- Reset asserted in cycle 100 → all outputs 0 the same cycle; no o_we. Restart reproduces the first scenario's result.
- NN_SEQ_BIAS_EN: all biases 5, layer-1 weights 0, layer-2 weights 1 → hid=5; outputs 8*5+5=45.
